// File: rtl/stage_mem.sv
// stage_mem: memory-access stage driving a request/ack data bus with byte-lane steering,
// sign extension, stall generation and a registered write-back result.
module stage_mem #(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] alu_result_in,
  input  logic [4:0]  wb_reg_addr_in,
  input  logic [2:0]  mem_opt_in,
  input  logic [31:0] mem_addr_in,
  input  logic [31:0] mem_data_in,
  output logic        stall_req,
  output logic        dev_req,
  output logic        dev_we,
  output logic [31:0] dev_addr,
  output logic [3:0]  dev_be,
  output logic [31:0] dev_wdata,
  input  logic [31:0] dev_rdata,
  input  logic        dev_ack,
  output logic [4:0]  wb_reg_addr,
  output logic [31:0] wb_data,
  output logic        addr_err,
  output logic        bus_err
);
  localparam int CW = $clog2(ACK_TIMEOUT + 1);
  typedef enum logic {IDLE, REQ} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] opt_q, opt_d;
  logic [4:0] rd_q, rd_d, wbr_q, wbr_d;
  logic [1:0] off_q, off_d;
  logic req_q, req_d, we_q, we_d, aerr_q, aerr_d, berr_q, berr_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, wbd_q, wbd_d, ld;
  logic [3:0] be_q, be_d;
  logic [7:0] lane;
  logic idle, word, mem, go, done, issue;
  assign idle = state_q == IDLE;
  assign word = mem_opt_in == 3'd1 || mem_opt_in == 3'd4;
  assign mem = mem_opt_in inside {[3'd1:3'd5]};
  assign go = mem && !(word && |mem_addr_in[1:0]);
  assign issue = idle && go;
  // done covers both the ack and the last cycle before the timeout abort
  assign done = dev_ack || cnt_q == CW'(ACK_TIMEOUT - 1);
  assign lane = dev_rdata[{off_q, 3'b000} +: 8];
  assign ld = opt_q == 3'd1 ? dev_rdata :
              opt_q == 3'd2 ? {{24{lane[7]}}, lane} :
              opt_q == 3'd3 ? {24'd0, lane} : '0;
  always_ff @(posedge clk) state_q <= rst ? IDLE : state_d;
  always_comb state_d = idle ? (go ? REQ : IDLE) : (done ? IDLE : REQ);
  always_comb begin
    stall_req = idle ? go : !done;
    cnt_d = idle ? '0 : cnt_q + CW'(1);
    opt_d = idle ? mem_opt_in : opt_q;
    rd_d = idle ? wb_reg_addr_in : rd_q;
    off_d = idle ? mem_addr_in[1:0] : off_q;
    req_d = idle ? go : !done;
    we_d = issue ? mem_opt_in >= 3'd4 : we_q;
    addr_d = issue ? {mem_addr_in[31:2], 2'b00} : addr_q;
    be_d = issue ? (word ? 4'hF : 4'b0001 << mem_addr_in[1:0]) : be_q;
    wdata_d = issue ? (mem_opt_in == 3'd5 ? {4{mem_data_in[7:0]}} : mem_data_in) : wdata_q;
    aerr_d = idle && mem && !go;
    berr_d = !idle && !dev_ack && done;
    wbr_d = idle ? (mem ? '0 : wb_reg_addr_in) : (dev_ack && opt_q < 3'd4 ? rd_q : '0);
    wbd_d = idle ? alu_result_in : (dev_ack ? ld : '0);
  end
  always_ff @(posedge clk)
    if (rst) begin
      cnt_q <= '0;
      opt_q <= '0;
      rd_q <= '0;
      off_q <= '0;
      req_q <= 1'b0;
      we_q <= 1'b0;
      addr_q <= '0;
      be_q <= '0;
      wdata_q <= '0;
      aerr_q <= 1'b0;
      berr_q <= 1'b0;
      wbr_q <= '0;
      wbd_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      opt_q <= opt_d;
      rd_q <= rd_d;
      off_q <= off_d;
      req_q <= req_d;
      we_q <= we_d;
      addr_q <= addr_d;
      be_q <= be_d;
      wdata_q <= wdata_d;
      aerr_q <= aerr_d;
      berr_q <= berr_d;
      wbr_q <= wbr_d;
      wbd_q <= wbd_d;
    end
  assign dev_req = req_q;
  assign dev_we = we_q;
  assign dev_addr = addr_q;
  assign dev_be = be_q;
  assign dev_wdata = wdata_q;
  assign addr_err = aerr_q;
  assign bus_err = berr_q;
  assign wb_reg_addr = wbr_q;
  assign wb_data = wbd_q;
endmodule

// File: tb/tb_stage_mem.sv
// tb_stage_mem: randomized self-checking bench for stage_mem against a behavioural
// model of the memory stage (load extension, lane enables, timeout, address errors).
module tb_stage_mem;
  localparam int TO = 4;
  logic clk = 0;
  logic rst;
  logic [31:0] alu_result_in, mem_addr_in, mem_data_in, dev_addr, dev_wdata, dev_rdata, wb_data;
  logic [4:0] wb_reg_addr_in, wb_reg_addr;
  logic [2:0] mem_opt_in;
  logic stall_req, dev_req, dev_we, dev_ack, addr_err, bus_err;
  logic [3:0] dev_be;
  int errors = 0;
  int checks = 0;

  typedef struct {
    logic stall; logic req; logic [31:0] addr; logic [3:0] be; logic we; logic [31:0] wdata;
    logic aerr; logic berr; logic [4:0] wb_rd; logic [31:0] wb_data; logic req_end; int ncyc; int bad;
  } obs_t;

  stage_mem #(.ACK_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .alu_result_in(alu_result_in), .wb_reg_addr_in(wb_reg_addr_in),
    .mem_opt_in(mem_opt_in), .mem_addr_in(mem_addr_in), .mem_data_in(mem_data_in),
    .stall_req(stall_req), .dev_req(dev_req), .dev_we(dev_we), .dev_addr(dev_addr),
    .dev_be(dev_be), .dev_wdata(dev_wdata), .dev_rdata(dev_rdata), .dev_ack(dev_ack),
    .wb_reg_addr(wb_reg_addr), .wb_data(wb_data), .addr_err(addr_err), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  // Value a load hands to write-back, computed arithmetically from the byte offset.
  function automatic logic [31:0] ref_load(input int op, input int off, input logic [31:0] rdata);
    int b;
    b = int'((rdata >> (8 * off)) & 32'hFF);
    if (op == 1) return rdata;
    if (op == 2) return b >= 128 ? 32'(b - 256) : 32'(b);
    if (op == 3) return 32'(b);
    return 32'd0;
  endfunction

  function automatic logic [3:0] ref_be(input int op, input logic [31:0] addr);
    return (op == 1 || op == 4) ? 4'hF : 4'(1 << addr[1:0]);
  endfunction

  task automatic idle();
    mem_opt_in = 0; mem_addr_in = 0; mem_data_in = 0; wb_reg_addr_in = 0; alu_result_in = 0; dev_ack = 0;
    @(negedge clk);
  endtask

  // Issues one op at the current negedge; ends at the negedge after the op completes.
  // ack_after = number of unacknowledged REQ cycles before dev_ack (>= TO means never).
  task automatic run(input int op, input logic [31:0] addr, input logic [31:0] data, input logic [4:0] rd,
                     input logic [31:0] alu, input int ack_after, input logic [31:0] rdata, output obs_t o);
    o = '{default: 0};
    mem_opt_in = 3'(op); mem_addr_in = addr; mem_data_in = data; wb_reg_addr_in = rd;
    alu_result_in = alu; dev_ack = 0;
    #1 o.stall = stall_req;
    @(negedge clk);
    o.req = dev_req; o.addr = dev_addr; o.be = dev_be; o.we = dev_we; o.wdata = dev_wdata; o.aerr = addr_err;
    if (dev_req) begin
      for (int k = 0; k < TO + 2; k++) begin
        logic hit;
        hit = (k == ack_after);
        if (dev_req !== 1'b1 || dev_addr !== o.addr || dev_be !== o.be || dev_we !== o.we || dev_wdata !== o.wdata) o.bad++;
        dev_ack = hit;
        dev_rdata = hit ? rdata : $urandom;
        #1 if (stall_req !== !(hit || k == TO - 1)) o.bad++;
        o.ncyc++;
        @(negedge clk);
        dev_ack = 0;
        if (hit || k == TO - 1) break;
      end
    end
    o.wb_rd = wb_reg_addr; o.wb_data = wb_data; o.berr = bus_err; o.req_end = dev_req;
  endtask

  task automatic test_reset();
    rst = 1; dev_rdata = 0;
    idle();
    repeat (2) @(negedge clk);
    checks++; if ({dev_req, dev_we, dev_addr, dev_be, dev_wdata} !== '0) begin errors++; $display("FAIL reset_bus: got req=%b we=%b addr=%h be=%h wdata=%h want all 0", dev_req, dev_we, dev_addr, dev_be, dev_wdata); end
    checks++; if ({wb_reg_addr, wb_data} !== '0) begin errors++; $display("FAIL reset_wb: got rd=%0d data=%h want 0", wb_reg_addr, wb_data); end
    checks++; if ({stall_req, addr_err, bus_err} !== 3'b000) begin errors++; $display("FAIL reset_flags: got stall=%b aerr=%b berr=%b want 0", stall_req, addr_err, bus_err); end
    rst = 0;
  endtask

  task automatic test_none();
    obs_t o;
    run(0, 32'h55, 32'h0, 5'd3, 32'h1234, 0, 0, o);
    checks++; if (o.wb_rd !== 5'd3 || o.wb_data !== 32'h1234) begin errors++; $display("FAIL none_wb: got rd=%0d data=%h want rd=3 data=00001234", o.wb_rd, o.wb_data); end
    checks++; if (o.stall !== 1'b0 || o.req !== 1'b0) begin errors++; $display("FAIL none_bus: got stall=%b req=%b want 0 0", o.stall, o.req); end
    for (int i = 0; i < 4; i++) begin
      int op;
      logic [31:0] alu;
      logic [4:0] rd;
      op = (i == 0) ? 0 : 5 + i;
      alu = $urandom; rd = 5'($urandom);
      run(op, $urandom, $urandom, rd, alu, 0, 0, o);
      checks++; if (o.wb_rd !== rd || o.wb_data !== alu || o.req !== 1'b0 || o.stall !== 1'b0) begin errors++; $display("FAIL none_rand op%0d: got rd=%0d data=%h req=%b stall=%b want rd=%0d data=%h req=0 stall=0", op, o.wb_rd, o.wb_data, o.req, o.stall, rd, alu); end
    end
    // A stray ack while idle must not start anything.
    mem_opt_in = 0; dev_ack = 1;
    @(negedge clk);
    dev_ack = 0;
    checks++; if (dev_req !== 1'b0 || bus_err !== 1'b0) begin errors++; $display("FAIL idle_ack: got req=%b berr=%b want 0 0", dev_req, bus_err); end
  endtask

  task automatic test_lw();
    obs_t o;
    run(1, 32'h100, 32'h0, 5'd5, 32'h0, 3, 32'hDEADBEEF, o);
    checks++; if (o.addr !== 32'h100 || o.be !== 4'hF || o.we !== 1'b0 || o.req !== 1'b1) begin errors++; $display("FAIL lw_bus: got addr=%h be=%h we=%b req=%b want 00000100 f 0 1", o.addr, o.be, o.we, o.req); end
    checks++; if (o.stall !== 1'b1 || o.bad !== 0 || o.ncyc !== 4) begin errors++; $display("FAIL lw_stall: got stall=%b bad=%0d cycles=%0d want 1 0 4", o.stall, o.bad, o.ncyc); end
    checks++; if (o.wb_rd !== 5'd5 || o.wb_data !== 32'hDEADBEEF || o.req_end !== 1'b0) begin errors++; $display("FAIL lw_wb: got rd=%0d data=%h req=%b want 5 deadbeef 0", o.wb_rd, o.wb_data, o.req_end); end
    for (int i = 0; i < 4; i++) begin
      logic [31:0] a, r;
      logic [4:0] rd;
      a = $urandom & 32'hFFFF_FFFC; r = $urandom; rd = 5'($urandom);
      run(1, a, $urandom, rd, $urandom, $urandom_range(0, 2), r, o);
      checks++; if (o.addr !== a || o.wb_rd !== rd || o.wb_data !== r || o.bad !== 0) begin errors++; $display("FAIL lw_rand: got addr=%h rd=%0d data=%h bad=%0d want %h %0d %h 0", o.addr, o.wb_rd, o.wb_data, o.bad, a, rd, r); end
    end
  endtask

  task automatic test_byte_loads();
    obs_t o;
    run(2, 32'h203, 32'h0, 5'd9, 32'h0, 1, 32'h80FFFFFF, o);
    checks++; if (o.be !== 4'b1000 || o.addr !== 32'h200 || o.wb_data !== 32'hFFFFFF80 || o.wb_rd !== 5'd9) begin errors++; $display("FAIL lb: got be=%b addr=%h data=%h rd=%0d want 1000 00000200 ffffff80 9", o.be, o.addr, o.wb_data, o.wb_rd); end
    run(3, 32'h203, 32'h0, 5'd9, 32'h0, 0, 32'h80FFFFFF, o);
    checks++; if (o.be !== 4'b1000 || o.wb_data !== 32'h00000080) begin errors++; $display("FAIL lbu: got be=%b data=%h want 1000 00000080", o.be, o.wb_data); end
    for (int i = 0; i < 8; i++) begin
      int op;
      logic [31:0] a, r;
      op = 2 + int'($urandom_range(0, 1)); a = $urandom; r = $urandom;
      run(op, a, $urandom, 5'd17, $urandom, $urandom_range(0, 2), r, o);
      checks++; if (o.be !== ref_be(op, a) || o.addr !== (a & 32'hFFFF_FFFC) || o.wb_data !== ref_load(op, a[1:0], r) || o.wb_rd !== 5'd17) begin errors++; $display("FAIL byte_rand op%0d a=%h: got be=%b data=%h rd=%0d want %b %h 17", op, a, o.be, o.wb_data, o.wb_rd, ref_be(op, a), ref_load(op, a[1:0], r)); end
    end
    // Load to x0 still uses the bus.
    run(1, 32'h40, 32'h0, 5'd0, 32'h0, 0, 32'h1111, o);
    checks++; if (o.req !== 1'b1 || o.wb_rd !== 5'd0) begin errors++; $display("FAIL lw_x0: got req=%b rd=%0d want 1 0", o.req, o.wb_rd); end
  endtask

  task automatic test_stores();
    obs_t o;
    run(5, 32'h301, 32'h000000AB, 5'd7, 32'h0, 0, 32'h0, o);
    checks++; if (o.addr !== 32'h300 || o.be !== 4'b0010 || o.wdata !== 32'hABABABAB || o.we !== 1'b1) begin errors++; $display("FAIL sb_bus: got addr=%h be=%b wdata=%h we=%b want 00000300 0010 abababab 1", o.addr, o.be, o.wdata, o.we); end
    checks++; if (o.wb_rd !== 5'd0 || o.ncyc !== 1 || o.stall !== 1'b1) begin errors++; $display("FAIL sb_wb: got rd=%0d cycles=%0d stall=%b want 0 1 1", o.wb_rd, o.ncyc, o.stall); end
    for (int i = 0; i < 6; i++) begin
      int op;
      logic [31:0] a, d, wd;
      op = (i % 2 == 0) ? 4 : 5; d = $urandom;
      a = (op == 4) ? ($urandom & 32'hFFFF_FFFC) : $urandom;
      wd = (op == 4) ? d : 32'(d[7:0]) * 32'h01010101;
      run(op, a, d, 5'd12, $urandom, $urandom_range(0, 2), $urandom, o);
      checks++; if (o.we !== 1'b1 || o.wdata !== wd || o.be !== ref_be(op, a) || o.wb_rd !== 5'd0 || o.wb_data !== 32'd0 || o.bad !== 0) begin errors++; $display("FAIL st_rand op%0d a=%h: got we=%b wdata=%h be=%b rd=%0d data=%h bad=%0d want 1 %h %b 0 0 0", op, a, o.we, o.wdata, o.be, o.wb_rd, o.wb_data, o.bad, wd, ref_be(op, a)); end
    end
  endtask

  task automatic test_misaligned();
    obs_t o;
    run(4, 32'h102, 32'h1, 5'd4, 32'h0, 0, 32'h0, o);
    checks++; if (o.aerr !== 1'b1 || o.req !== 1'b0 || o.wb_rd !== 5'd0 || o.stall !== 1'b0) begin errors++; $display("FAIL sw_mis: got aerr=%b req=%b rd=%0d stall=%b want 1 0 0 0", o.aerr, o.req, o.wb_rd, o.stall); end
    idle();
    checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL aerr_pulse: got %b want 0", addr_err); end
    run(1, 32'h1001, 32'h0, 5'd8, 32'h0, 0, 32'h0, o);
    checks++; if (o.aerr !== 1'b1 || o.req !== 1'b0 || o.wb_rd !== 5'd0) begin errors++; $display("FAIL lw_mis: got aerr=%b req=%b rd=%0d want 1 0 0", o.aerr, o.req, o.wb_rd); end
  endtask

  task automatic test_timeout();
    obs_t o;
    run(1, 32'h40, 32'h0, 5'd9, 32'h0, 99, 32'h0, o);
    checks++; if (o.ncyc !== TO || o.berr !== 1'b1 || o.req_end !== 1'b0 || o.wb_rd !== 5'd0 || o.bad !== 0) begin errors++; $display("FAIL timeout: got cycles=%0d berr=%b req=%b rd=%0d bad=%0d want %0d 1 0 0 0", o.ncyc, o.berr, o.req_end, o.wb_rd, o.bad, TO); end
    run(0, 32'h0, 32'h0, 5'd2, 32'h77, 0, 32'h0, o);
    checks++; if (o.berr !== 1'b0 || o.wb_rd !== 5'd2 || o.wb_data !== 32'h77) begin errors++; $display("FAIL after_timeout: got berr=%b rd=%0d data=%h want 0 2 00000077", o.berr, o.wb_rd, o.wb_data); end
  endtask

  task automatic test_reset_mid_req();
    mem_opt_in = 1; mem_addr_in = 32'h80; wb_reg_addr_in = 5'd6; alu_result_in = 0; dev_ack = 0;
    @(negedge clk);
    checks++; if (dev_req !== 1'b1) begin errors++; $display("FAIL rst_req_start: got req=%b want 1", dev_req); end
    @(negedge clk);
    rst = 1; mem_opt_in = 0; wb_reg_addr_in = 0; mem_addr_in = 0;
    @(negedge clk);
    checks++; if ({dev_req, dev_we, dev_addr, dev_be, dev_wdata, wb_reg_addr, wb_data, addr_err, bus_err, stall_req} !== '0) begin errors++; $display("FAIL rst_mid: got req=%b addr=%h be=%b rd=%0d data=%h stall=%b want all 0", dev_req, dev_addr, dev_be, wb_reg_addr, wb_data, stall_req); end
    rst = 0; dev_ack = 1; dev_rdata = 32'hCAFE;
    @(negedge clk);
    dev_ack = 0;
    checks++; if (dev_req !== 1'b0 || wb_reg_addr !== 5'd0 || wb_data !== 32'd0) begin errors++; $display("FAIL rst_late_ack: got req=%b rd=%0d data=%h want 0 0 0", dev_req, wb_reg_addr, wb_data); end
  endtask

  task automatic test_back_to_back();
    obs_t o;
    for (int i = 0; i < 20; i++) begin
      int op, ack;
      logic [31:0] a, d, alu, r;
      logic [4:0] rd, erd;
      logic mem, mis, legal, tout;
      op = int'($urandom_range(0, 7)); a = $urandom; d = $urandom; alu = $urandom; r = $urandom;
      rd = 5'($urandom);
      ack = ($urandom_range(0, 7) == 0) ? 99 : int'($urandom_range(0, 2));
      run(op, a, d, rd, alu, ack, r, o);
      mem = op >= 1 && op <= 5;
      mis = (op == 1 || op == 4) && a[1:0] != 2'b00;
      legal = mem && !mis;
      tout = legal && ack >= TO;
      erd = !mem ? rd : (legal && !tout && op <= 3) ? rd : 5'd0;
      checks++; if (o.wb_rd !== erd || o.aerr !== mis || o.berr !== tout || o.stall !== legal || o.bad !== 0) begin errors++; $display("FAIL b2b[%0d] op%0d a=%h: got rd=%0d aerr=%b berr=%b stall=%b bad=%0d want %0d %b %b %b 0", i, op, a, o.wb_rd, o.aerr, o.berr, o.stall, o.bad, erd, mis, tout, legal); end
      if (!mem || (legal && !tout)) begin
        logic [31:0] ed;
        ed = !mem ? alu : ref_load(op, a[1:0], r);
        checks++; if (o.wb_data !== ed) begin errors++; $display("FAIL b2b_data[%0d] op%0d: got %h want %h", i, op, o.wb_data, ed); end
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_none();
    test_lw();
    test_byte_loads();
    test_stores();
    test_misaligned();
    test_timeout();
    test_reset_mid_req();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/stage_mem.md
Name: stage_mem

Overview:
- Memory-access stage, directly downstream of the execute stage.
- Consumes the execute stage's registered outputs: ALU result, write-back register address, memory op, memory address and store data.
- Drives a single-master, request/acknowledge data bus. Handles LW/LB/LBU/SW/SB with byte-lane steering and sign extension.
- Asserts a stall to freeze upstream stages during bus wait. Presents a registered result to write-back.

Parameters:
- ACK_TIMEOUT, 255: maximum cycles in REQ without dev_ack before the access is aborted with bus_err.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- alu_result_in  in  32  ALU result from execute
- wb_reg_addr_in  in  5  destination register; 0 means no write
- mem_opt_in  in  3  0=NONE, 1=LW, 2=LB, 3=LBU, 4=SW, 5=SB; 6 and 7 are treated as NONE
- mem_addr_in  in  32  byte address
- mem_data_in  in  32  store data
- stall_req  out  1  freeze execute and earlier stages; combinational
- dev_req  out  1  bus request; registered
- dev_we  out  1  1 = write
- dev_addr  out  32  word address; low 2 bits are 0
- dev_be  out  4  byte enables; bit i enables byte lane i (little-endian)
- dev_wdata  out  32  write data
- dev_rdata  in  32  read data, valid in the cycle dev_ack=1
- dev_ack  in  1  single-cycle acknowledge
- wb_reg_addr  out  5  to write-back; registered
- wb_data  out  32  to write-back; registered
- addr_err  out  1  one-cycle pulse on misaligned LW/SW
- bus_err  out  1  one-cycle pulse on ACK_TIMEOUT expiry

Behaviour:
- States: IDLE, REQ. Reset forces IDLE.
- Reset values: all outputs 0, timeout counter 0. Reset mid-REQ drops dev_req in the same edge; no write-back is produced.
- IDLE, op NONE:
  - Next edge: wb_reg_addr<=wb_reg_addr_in, wb_data<=alu_result_in.
  - stall_req=0. Latency is 1 cycle.
- IDLE, mem op with LW/SW and mem_addr_in[1:0]!=0:
  - No bus access. addr_err pulses for 1 cycle. wb_reg_addr<=0. stall_req=0.
- IDLE, legal mem op:
  - stall_req=1.
  - Next edge: state<=REQ, dev_req<=1, dev_addr<={mem_addr_in[31:2],2'b00}, dev_we<=(SW|SB), counter<=0.
  - Latch opt, wb_reg_addr_in and addr[1:0] internally. wb_reg_addr<=0 (bubble).
  - LW/SW: dev_be=4'hF, dev_wdata=mem_data_in.
  - LB/LBU: dev_be=4'b0001<<addr[1:0].
  - SB: dev_be as for LB; dev_wdata={4{mem_data_in[7:0]}}.
- REQ:
  - stall_req=!dev_ack. Bus outputs are held stable until ack.
  - On dev_ack, next edge: dev_req<=0, state<=IDLE, wb_reg_addr<=latched addr (0 for stores).
  - wb_data on dev_ack: LW gives dev_rdata. LB gives sign-extended byte lane addr[1:0]. LBU gives zero-extended byte lane. Stores give 0.
  - Upstream advances on the same edge, so the next op is seen in IDLE on the following cycle.
  - No ack: counter increments. When counter==ACK_TIMEOUT-1 without ack, next edge: dev_req<=0, IDLE, bus_err pulse, wb_reg_addr<=0, stall released in that cycle.
- dev_ack outside REQ is ignored.
- Load with wb_reg_addr_in=0 still performs the bus access.
- Back-to-back mem ops: each costs at least 2 cycles (IDLE issue plus REQ ack). There is no pipelining of bus requests.

Test Plan:
1. Reset, then op NONE, alu_result_in=0x1234, wb_reg_addr_in=3 -> next cycle wb_reg_addr=3, wb_data=0x1234, stall_req=0, dev_req=0.
2. LW addr 0x100, ack after 3 cycles with rdata 0xDEADBEEF, dest 5 -> dev_addr=0x100, be=F, we=0. stall_req is high until the ack cycle. Then wb_reg_addr=5, wb_data=0xDEADBEEF.
3. LB addr 0x203 with rdata 0x80FFFFFF -> be=4'b1000, wb_data=0xFFFFFF80. LBU at the same address -> 0x00000080.
4. SB addr 0x301 with data 0xAB, immediate ack -> dev_addr=0x300, be=4'b0010, dev_wdata=0xABABABAB, we=1, wb_reg_addr=0.
5. SW addr 0x102 -> addr_err pulse, dev_req stays 0, wb_reg_addr=0. Separately, LW with no ack and ACK_TIMEOUT=4 -> bus_err after 4 REQ cycles, then IDLE.
6. rst asserted in REQ cycle 2 -> next cycle dev_req=0, stall_req=0, all outputs 0. A later dev_ack is ignored.
